pipelined_cs_addsub: RTL
========================

# pipelined_cs_addsub

Parametrised, pipelined carry-select adder/subtractor with a valid/ready handshake on both sides. The WIDTH-bit operands are split into NBLK = WIDTH/BLOCK blocks. Stage 0 computes both carry candidates for every block. Each later stage resolves one block's select from the registered carry of the stage before it. The block sits between the ALU operand registers and the writeback mux, and gives full throughput at a WIDTH-independent cycle time.

## Interface
Parameters:
- WIDTH, 32, operand/result width; must be a multiple of BLOCK.
- BLOCK, 8, bits per carry-select block; NBLK = WIDTH/BLOCK, NBLK >= 1.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  operand beat offered.
- in_ready  out  1  block can accept a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- sub  in  1  0: a+b+carry_in; 1: a+~b+1 (carry_in ignored).
- carry_in  in  1  carry into bit 0 when sub=0.
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts result this cycle.
- sum  out  WIDTH  result.
- carry_out  out  1  carry out of bit WIDTH-1. For sub, 1 means no borrow.
- overflow  out  1  two's-complement overflow.
- zero  out  1  sum == 0.

## Operation
- Effective operands:
  - beff = sub ? ~b : b.
  - c0 = sub ? 1 : carry_in.
- Stage 0 (registered at accept):
  - For block 0: final sum and carry using c0.
  - For blocks 1..NBLK-1: sum0/carry0 (cin=0) and sum1/carry1 (cin=1).
  - Also registered: the a MSB and the beff MSB.
- Stage k (1..NBLK-1): block k selects sum1/carry1 if the registered carry out of block k-1 is 1, else sum0/carry0. Resolved blocks and unresolved candidates move forward with the beat.
- Final stage outputs:
  - carry_out = resolved carry of block NBLK-1.
  - overflow = (a_msb == beff_msb) && (sum[WIDTH-1] != a_msb).
  - zero = ~|sum.
- Every pipeline stage holds one valid bit. Each beat flows in order; there is no reordering, duplication or loss.
- Pipeline advance:
  - adv = ~reset && (~out_valid || out_ready).
  - All stages shift together when adv=1 and hold when adv=0. Bubbles also hold under stall; there is no bubble collapsing.
- in_ready = adv. A beat is accepted when in_valid && in_ready.
- A stage that shifts in no accepted beat is loaded with valid=0.

## Timing
- Latency: NBLK cycles from accept edge to out_valid=1, with no stall (WIDTH=32, BLOCK=8 → 4 cycles).
- Throughput: one beat per cycle while out_ready=1.
- Stall: while out_valid=1 and out_ready=0, all of the following hold:
  - sum, carry_out, overflow, zero and out_valid are held stable.
  - in_ready=0.
- Handshake is combinational on out_ready → in_ready; there are no other combinational input→output paths.
- Output data changes only on an edge where adv=1.
- Simultaneous out_ready=1 and in_valid=1 while the pipe is full: the output beat retires and the new beat enters on the same edge.
- Reset (synchronous, any cycle, including mid-stream):
  - All valid bits clear on the next edge.
  - sum=0, carry_out=0, overflow=0, zero=0, out_valid=0.
  - in_ready=0 while reset=1.
  - In-flight beats are discarded.
  - The first beat can be accepted in the first cycle after reset deasserts.
- NBLK=1: single stage, latency 1, no select stages.
- Width rules:
  - All arithmetic is modulo 2^WIDTH.
  - Carry beyond bit WIDTH-1 appears only on carry_out.

## Test plan
All scenarios use WIDTH=32, BLOCK=8; each result appears 4 cycles after its accept edge.
- Reset: hold reset 2 cycles, including with in_valid=1 → out_valid=0, sum=0, in_ready=0, and no beat appears afterward.
- Add across a block boundary: a=0x000000FF, b=0x00000001, cin=0 → sum=0x00000100, carry_out=0, overflow=0, zero=0.
- Carry through all blocks: a=0xFFFFFFFF, b=0, cin=1 → sum=0, carry_out=1, zero=1, overflow=0.
- Overflow cases:
  - a=0x7FFFFFFF, b=1 → sum=0x80000000, overflow=1, carry_out=0.
  - sub with a=0x80000000, b=1 → sum=0x7FFFFFFF, overflow=1, carry_out=1.
  - sub with a=5, b=5 → sum=0, zero=1, carry_out=1.
- Backpressure: stream 10 random beats back-to-back, dropping out_ready for 3 cycles mid-stream → every result matches the reference model in order, and in_ready=0 for exactly those 3 cycles.
- Reset mid-stream: with 3 beats in flight, assert reset 1 cycle → none of the 3 appear, and the next accepted beat appears 4 cycles after its accept edge.

Source files
------------

// File: rtl/pipelined_cs_addsub.sv
// rtl/pipelined_cs_addsub.sv - pipelined carry-select adder/subtractor with valid/ready handshake
module pipelined_cs_addsub #(
   parameter int WIDTH = 32,
   parameter int BLOCK = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   input  logic             carry_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             overflow,
   output logic             zero
);

   localparam int NBLK = WIDTH / BLOCK;
   localparam int LAST = NBLK - 1;

   // Per-stage state. Stage k has blocks 0..k resolved in res_q[k] and the
   // carry out of block k in cy_q[k]; candidates ride along for later stages.
   logic [NBLK-1:0]  v_q;
   logic [NBLK-1:0]  cy_q;
   logic [NBLK-1:0]  am_q;
   logic [NBLK-1:0]  bm_q;
   logic [WIDTH-1:0] res_q [NBLK];
   logic [WIDTH-1:0] s0_q  [NBLK];
   logic [WIDTH-1:0] s1_q  [NBLK];
   logic [NBLK-1:0]  c0_q  [NBLK];
   logic [NBLK-1:0]  c1_q  [NBLK];

   logic             adv;
   logic [WIDTH-1:0] beff;
   logic             cin0;
   logic [WIDTH-1:0] st0_s0;
   logic [WIDTH-1:0] st0_s1;
   logic [NBLK-1:0]  st0_c0;
   logic [NBLK-1:0]  st0_c1;
   logic [WIDTH-1:0] st0_res;
   logic             st0_cy;
   logic [WIDTH-1:0] nxt_res [NBLK];
   logic [NBLK-1:0]  nxt_cy;

   // The whole pipe moves as one; a stalled output freezes every stage.
   assign adv      = ~reset & (~out_valid | out_ready);
   assign in_ready = adv;

   // Stage 0: both carry candidates per block; block 0 resolved with the real carry-in.
   always_comb begin
      logic [BLOCK:0] t0;
      logic [BLOCK:0] t1;
      logic [BLOCK:0] tb0;
      beff    = sub ? ~b : b;
      cin0    = sub | carry_in;
      st0_s0  = '0;
      st0_s1  = '0;
      st0_c0  = '0;
      st0_c1  = '0;
      for (int k = 0; k < NBLK; k++) begin
         t0 = {1'b0, a[k*BLOCK +: BLOCK]} + {1'b0, beff[k*BLOCK +: BLOCK]};
         t1 = t0 + (BLOCK+1)'(1);
         st0_s0[k*BLOCK +: BLOCK] = t0[BLOCK-1:0];
         st0_s1[k*BLOCK +: BLOCK] = t1[BLOCK-1:0];
         st0_c0[k] = t0[BLOCK];
         st0_c1[k] = t1[BLOCK];
      end
      tb0 = {1'b0, a[BLOCK-1:0]} + {1'b0, beff[BLOCK-1:0]} + {{BLOCK{1'b0}}, cin0};
      st0_res              = st0_s0;
      st0_res[BLOCK-1:0]   = tb0[BLOCK-1:0];
      st0_cy               = tb0[BLOCK];
   end

   // Stage k picks block k's candidate from the registered carry of block k-1.
   always_comb begin
      for (int k = 0; k < NBLK; k++) begin
         nxt_res[k] = '0;
      end
      nxt_cy = '0;
      for (int k = 1; k < NBLK; k++) begin
         nxt_res[k] = res_q[k-1];
         nxt_res[k][k*BLOCK +: BLOCK] = cy_q[k-1] ? s1_q[k-1][k*BLOCK +: BLOCK]
                                                  : s0_q[k-1][k*BLOCK +: BLOCK];
         nxt_cy[k] = cy_q[k-1] ? c1_q[k-1][k] : c0_q[k-1][k];
      end
   end

   // Pipeline registers: clear on reset, shift together on adv, otherwise hold.
   always_ff @(posedge clock) begin
      if (reset) begin
         v_q  <= '0;
         cy_q <= '0;
         am_q <= '0;
         bm_q <= '0;
         for (int k = 0; k < NBLK; k++) begin
            res_q[k] <= '0;
            s0_q[k]  <= '0;
            s1_q[k]  <= '0;
            c0_q[k]  <= '0;
            c1_q[k]  <= '0;
         end
      end else if (adv) begin
         v_q[0]   <= in_valid;
         res_q[0] <= st0_res;
         cy_q[0]  <= st0_cy;
         s0_q[0]  <= st0_s0;
         s1_q[0]  <= st0_s1;
         c0_q[0]  <= st0_c0;
         c1_q[0]  <= st0_c1;
         am_q[0]  <= a[WIDTH-1];
         bm_q[0]  <= beff[WIDTH-1];
         for (int k = 1; k < NBLK; k++) begin
            v_q[k]   <= v_q[k-1];
            res_q[k] <= nxt_res[k];
            cy_q[k]  <= nxt_cy[k];
            s0_q[k]  <= s0_q[k-1];
            s1_q[k]  <= s1_q[k-1];
            c0_q[k]  <= c0_q[k-1];
            c1_q[k]  <= c1_q[k-1];
            am_q[k]  <= am_q[k-1];
            bm_q[k]  <= bm_q[k-1];
         end
      end
   end

   // Final stage drives the result; zero is qualified so a cleared pipe reports 0.
   assign out_valid = v_q[LAST];
   assign sum       = res_q[LAST];
   assign carry_out = cy_q[LAST];
   assign overflow  = (am_q[LAST] == bm_q[LAST]) && (res_q[LAST][WIDTH-1] != am_q[LAST]);
   assign zero      = v_q[LAST] & ~|res_q[LAST];

endmodule
